imem_bank: RTL and testbench
============================

# imem_bank

Instruction memory for the RV32I core. Sits directly downstream of the SPI boot/echo wrapper: it consumes that block's `imem_wr_en` / `prog_addr` / `prog_instr` programming stream and serves single-cycle-latency instruction fetches to the CPU. It also publishes program bookkeeping (write count, checksum, written-word map) so firmware and test benches can confirm a download.

## Interface

Parameters:
- `DEPTH`, 16: number of 32-bit instruction words; must be a power of two.
- `ADDR_W`, 4: word-index width; equals log2(`DEPTH`).
- `NOP_INSTR`, 32'h0000_0013: word returned for faulted or unprogrammed fetches (`addi x0,x0,0`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_rst_n`  in  1  CPU reset from the wrapper; while low, fetches are ignored.
- `imem_wr_en`  in  1  program write enable; a level that may stay high for several cycles.
- `prog_addr`  in  ADDR_W  word index for the program write.
- `prog_instr`  in  32  program write data.
- `fetch_req`  in  1  CPU fetch request, one per cycle maximum.
- `fetch_pc`  in  32  byte address of the fetch.
- `fetch_valid`  out  1  response strobe.
- `fetch_instr`  out  32  fetched instruction.
- `fetch_fault`  out  1  fetch was misaligned or out of range; valid with `fetch_valid`.
- `written_map`  out  DEPTH  bit i = word i written since reset.
- `prog_count`  out  8  number of accepted writes since reset, saturating at 255.
- `prog_checksum`  out  32  sum mod 2^32 of all accepted write data since reset.

## Operation

Write port:
- A write is accepted only on the **rising edge** of `imem_wr_en`: `imem_wr_en`=1 while the internal `wr_en_q`=0. Holding the signal high produces exactly one write.
- On an accepted write:
  - `mem[prog_addr]` ← `prog_instr`.
  - `written_map[prog_addr]` ← 1.
  - `prog_count` increments, saturating at 255.
  - `prog_checksum` += `prog_instr`, 32-bit wrap.
- Rewriting the same index overwrites the word. Count and checksum still accumulate, and the map bit stays 1.
- Writes are accepted regardless of `cpu_rst_n`.

Fetch port:
- A fetch is accepted when `fetch_req`=1 and `cpu_rst_n`=1. Otherwise it is dropped and no response is generated.
- Word index = `fetch_pc[ADDR_W+1:2]`.
- Fault when `fetch_pc[1:0]`≠0, or any bit of `fetch_pc[31:ADDR_W+2]` is 1.
- Response data, in priority order:
  - fault: `NOP_INSTR` with `fetch_fault`=1.
  - else, map bit clear: `NOP_INSTR` with `fetch_fault`=0.
  - else: memory word with `fetch_fault`=0.
- Write/fetch collision (accepted write and accepted fetch in the same cycle, same index): the response returns the **new** `prog_instr`, and the word is treated as written.

Reset (`rst`=1 at a clock edge):
- Cleared to 0: `fetch_valid`, `fetch_fault`, `fetch_instr`, `written_map`, `prog_count`, `prog_checksum`, `wr_en_q`.
- Memory array contents are not cleared; `written_map` masks them.
- Reset has priority over any same-cycle write or fetch. Neither takes effect.
- If `imem_wr_en` is still high after reset releases, no write occurs, because `wr_en_q` is loaded from `imem_wr_en` each non-reset cycle.

## Timing

- Write: accepted in cycle N. Memory, map, count and checksum are visible from cycle N+1.
- Fetch: accepted in cycle N. `fetch_valid`=1 for exactly cycle N+1, with `fetch_instr` and `fetch_fault` registered.
  - Back-to-back requests give back-to-back responses. Throughput is one fetch per cycle.
  - `fetch_instr` holds its last value while `fetch_valid`=0.
- If `cpu_rst_n` falls in cycle N, a fetch requested in cycle N is dropped, and the response to the cycle N-1 fetch still appears in cycle N.
- Edge detector: `wr_en_q` ← `imem_wr_en` every non-reset cycle. A one-cycle low gap between two highs yields two writes.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- **Reset state:** assert `rst` 2 cycles with `fetch_req`=1 and `imem_wr_en`=1. Then release `rst` and drop `imem_wr_en`.
  - Required: all outputs 0 throughout reset, and no write afterwards (`prog_count`=0, `written_map`=0).
- **Program and fetch:**
  - Stimulus: hold `imem_wr_en` high 5 cycles with `prog_addr`=3, `prog_instr`=32'h0010_0093. Then set `cpu_rst_n`=1 and fetch `fetch_pc`=32'h0C.
  - Required: `prog_count`=1, `prog_checksum`=32'h0010_0093, `written_map`=16'h0008. The fetch returns 32'h0010_0093 one cycle later with fault=0.
- **Unprogrammed and fault cases:** fetch `fetch_pc` 32'h10, then 32'h0E, then 32'h40.
  - 32'h10 → 32'h13 with fault=0.
  - 32'h0E → 32'h13 with fault=1.
  - 32'h40 → 32'h13 with fault=1.
  - Required: three consecutive `fetch_valid` cycles.
- **Collision:** in the same cycle, write index 5 with 32'hDEAD_BEEF and fetch `fetch_pc`=32'h14.
  - Required: the next-cycle response is 32'hDEAD_BEEF with fault=0.
- **Saturation and wrap:**
  - Stimulus: 256 rising edges on `imem_wr_en`, each writing 32'h8000_0000. Then write 32'hFFFF_FFFF to index 0 after a checksum of 32'h0000_0001.
  - Required: after the 256 edges, `prog_count`=255 and `prog_checksum`=0. After the final write, `prog_checksum`=0.
- **CPU reset gating:** `cpu_rst_n`=0 with `fetch_req`=1 for 4 cycles.
  - Required: `fetch_valid` stays 0. Writes during this window are still accepted.

Source files
------------

// File: rtl/imem_bank.sv
// rtl/imem_bank.sv - instruction memory with edge-triggered programming port and single-cycle fetch
module imem_bank #(
    parameter int          DEPTH     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rst_n,
    input  logic              imem_wr_en,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_instr,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_pc,
    output logic              fetch_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_fault,
    output logic [DEPTH-1:0]  written_map,
    output logic [7:0]        prog_count,
    output logic [31:0]       prog_checksum
);

    logic [31:0]       mem [DEPTH];
    logic              wr_en_q;
    logic              wr_acc;
    logic              fetch_acc;
    logic [ADDR_W-1:0] fetch_idx;
    logic              fault;
    logic [31:0]       resp_instr;

    assign wr_acc    = imem_wr_en && !wr_en_q;
    assign fetch_acc = fetch_req && cpu_rst_n;
    assign fetch_idx = fetch_pc[ADDR_W+1:2];
    assign fault     = (|fetch_pc[1:0]) || (|fetch_pc[31:ADDR_W+2]);

    // A same-cycle write to the fetched index forwards the incoming word.
    always_comb begin
        resp_instr = NOP_INSTR;
        if (fault) begin
            resp_instr = NOP_INSTR;
        end else if (wr_acc && (prog_addr == fetch_idx)) begin
            resp_instr = prog_instr;
        end else if (written_map[fetch_idx]) begin
            resp_instr = mem[fetch_idx];
        end
    end

    // Array is left uncleared by reset; written_map masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[prog_addr] <= prog_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q       <= 1'b0;
            written_map   <= '0;
            prog_count    <= 8'd0;
            prog_checksum <= 32'd0;
        end else begin
            wr_en_q <= imem_wr_en;
            if (wr_acc) begin
                written_map[prog_addr] <= 1'b1;
                prog_checksum          <= prog_checksum + prog_instr;
                if (prog_count != 8'hFF) begin
                    prog_count <= prog_count + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fetch_instr <= 32'd0;
        end else begin
            fetch_valid <= fetch_acc;
            if (fetch_acc) begin
                fetch_fault <= fault;
                fetch_instr <= resp_instr;
            end
        end
    end

endmodule

// File: tb/tb_imem_bank.sv
// tb/tb_imem_bank.sv - scoreboard testbench for imem_bank
module tb_imem_bank;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_rst_n = 1'b0;
    logic        imem_wr_en = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_instr = '0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_fault;
    logic [15:0] written_map;
    logic [7:0]  prog_count;
    logic [31:0] prog_checksum;

    imem_bank dut (
        .clk(clk), .rst(rst), .cpu_rst_n(cpu_rst_n), .imem_wr_en(imem_wr_en),
        .prog_addr(prog_addr), .prog_instr(prog_instr), .fetch_req(fetch_req),
        .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
        .fetch_fault(fetch_fault), .written_map(written_map),
        .prog_count(prog_count), .prog_checksum(prog_checksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] m_mem [16];
    logic [15:0] m_map = '0;
    logic        m_wq = 1'b0;
    logic [7:0]  m_count = '0;
    logic [31:0] m_sum = '0;
    logic [31:0] last_instr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_valid", {63'd0, fetch_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("fetch_instr", {32'd0, fetch_instr}, {32'd0, e.instr});
                check("fetch_fault", {63'd0, fetch_fault}, {63'd0, e.fault});
                check("fetch_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Drive one cycle of inputs, predict any fetch response, then advance the model.
    task automatic drive(input logic r, input logic w, input logic [3:0] addr,
                         input logic [31:0] data, input logic req, input logic [31:0] pc);
        logic acc_w;
        logic flt;
        logic [3:0] idx;
        exp_t e;
        rst = r; imem_wr_en = w; prog_addr = addr; prog_instr = data;
        fetch_req = req; fetch_pc = pc;
        acc_w = !r && w && !m_wq;
        if (!r && req && cpu_rst_n) begin
            idx = pc[5:2];
            flt = (pc[1:0] != 2'b00) || (pc[31:6] != 26'd0);
            e.fault = flt;
            if (flt) e.instr = NOP;
            else if (acc_w && addr == idx) e.instr = data;
            else if (!m_map[idx]) e.instr = NOP;
            else e.instr = m_mem[idx];
            e.cyc = cyc + 1;
            last_instr = e.instr;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_wq = 1'b0; m_map = '0; m_count = '0; m_sum = '0;
        end else begin
            m_wq = w;
            if (acc_w) begin
                m_mem[addr] = data;
                m_map[addr] = 1'b1;
                if (m_count != 8'hFF) m_count = m_count + 8'd1;
                m_sum = m_sum + data;
            end
        end
    endtask

    initial begin
        cpu_rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'd2, 32'h1234_5678, 1'b1, 32'h8);
            check("rst_valid", {63'd0, fetch_valid}, 64'd0);
            check("rst_outs", {fetch_instr, 16'd0, written_map}, 64'd0);
            check("rst_cnt", {24'd0, prog_count, prog_checksum}, 64'd0);
        end
        drive(1'b0, 1'b0, 4'd2, 32'h1234_5678, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        check("post_rst_count", {56'd0, prog_count}, 64'd0);
        check("post_rst_map", {48'd0, written_map}, 64'd0);

        cpu_rst_n = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 4'd3, 32'h0010_0093, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        check("prog_count", {56'd0, prog_count}, 64'd1);
        check("prog_checksum", {32'd0, prog_checksum}, 64'h0010_0093);
        check("written_map", {48'd0, written_map}, 64'h0008);

        cpu_rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0C);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h10);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0E);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h40);
        drive(1'b0, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b1, 32'h14);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h14);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0C);

        // cpu_rst_n falls while the previous response is still due
        cpu_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i == 1), 4'd7, 32'hCAFE_0007, 1'b1, 32'h1C);
            if (i > 0) check("gated_valid", {63'd0, fetch_valid}, 64'd0);
        end
        check("gated_hold", {32'd0, fetch_instr}, {32'd0, last_instr});
        check("gated_write_map", {63'd0, written_map[7]}, 64'd1);
        check("gated_write_sum", {32'd0, prog_checksum}, {32'd0, m_sum});
        cpu_rst_n = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h1C);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);

        drive(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 4'(i), 32'h8000_0000, 1'b0, 32'h0);
            drive(1'b0, 1'b0, 4'(i), 32'h8000_0000, 1'b0, 32'h0);
        end
        check("sat_count", {56'd0, prog_count}, 64'd255);
        check("sat_checksum", {32'd0, prog_checksum}, 64'd0);
        drive(1'b0, 1'b1, 4'd1, 32'h0000_0001, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 4'd1, 32'h0, 1'b0, 32'h0);
        check("wrap_pre", {32'd0, prog_checksum}, 64'd1);
        drive(1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b1, 32'h0);
        check("wrap_checksum", {32'd0, prog_checksum}, 64'd0);
        check("wrap_count", {56'd0, prog_count}, 64'd255);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0);
        check("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
